alu64_unit: RTL and testbench

- 64-bit two's-complement ALU for the Y86-64 pipeline execute stage.
- Performs add, subtract, AND or XOR on two operands, selected by a 2-bit control code.
- Result and signed-overflow flag are registered: one clock of latency.
- The execute stage derives its condition codes (ZF/SF/OF) from these outputs.

---
 rtl/alu_pkg.sv | 17 +
 rtl/add_sub64.sv | 78 +++++++
 rtl/alu64_unit.sv | 71 +++++++
 tb/tb_alu64_unit.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pkg
//  Purpose  : Shared operation codes and word width for the Y86-64 ALU.
//  Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int          WORD_W  = 64;

    localparam logic [1:0]  ALU_ADD = 2'd0;
    localparam logic [1:0]  ALU_SUB = 2'd1;
    localparam logic [1:0]  ALU_AND = 2'd2;
    localparam logic [1:0]  ALU_XOR = 2'd3;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/add_sub64.sv
`default_nettype none
// ============================================================================
//  Module   : add_sub64
//  Purpose  : Combinational two's-complement adder/subtractor built from
//             4-bit carry-lookahead groups rippling between groups.
//  Revision : 1.0 - initial release
// ============================================================================
module add_sub64
    import alu_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             overflow
);

    localparam int C_GROUPS = WIDTH / 4;

    logic [WIDTH-1:0]    w_b_eff;
    logic [WIDTH-1:0]    w_p;
    logic [WIDTH-1:0]    w_g;
    logic [C_GROUPS-1:0] w_grp_g;
    logic [C_GROUPS-1:0] w_grp_p;
    logic [C_GROUPS-1:0] w_grp_cin;

    // Subtraction is A + ~B + 1: invert B and inject the +1 as carry-in.
    assign w_b_eff = b ^ {WIDTH{sub}};
    assign w_p     = a ^ w_b_eff;
    assign w_g     = a & w_b_eff;

    for (genvar k = 0; k < C_GROUPS; k++) begin : g_group_pg
        logic [3:0] p;
        logic [3:0] g;

        assign p = w_p[4*k +: 4];
        assign g = w_g[4*k +: 4];

        assign w_grp_g[k] = g[3]
                          | (p[3] & g[2])
                          | (p[3] & p[2] & g[1])
                          | (p[3] & p[2] & p[1] & g[0]);
        assign w_grp_p[k] = &p;
    end

    always_comb begin
        logic c;
        c         = sub;
        w_grp_cin = '0;
        for (int k = 0; k < C_GROUPS; k++) begin
            w_grp_cin[k] = c;
            c            = w_grp_g[k] | (w_grp_p[k] & c);
        end
    end

    for (genvar k = 0; k < C_GROUPS; k++) begin : g_group_sum
        logic [3:0] p;
        logic [3:0] g;
        logic [3:0] c;

        assign p    = w_p[4*k +: 4];
        assign g    = w_g[4*k +: 4];
        assign c[0] = w_grp_cin[k];
        assign c[1] = g[0] | (p[0] & c[0]);
        assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                    | (p[2] & p[1] & p[0] & c[0]);

        assign sum[4*k +: 4] = p ^ c;
    end

    // Signed overflow: effective operands agree in sign but the result does not.
    assign overflow = (a[WIDTH-1] == w_b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule : add_sub64
`default_nettype wire

// File: rtl/alu64_unit.sv
`default_nettype none
// ============================================================================
//  Module   : alu64_unit
//  Purpose  : Registered 64-bit add/sub/and/xor ALU with signed overflow flag
//             for the Y86-64 execute stage; one cycle of latency.
//  Revision : 1.0 - initial release
// ============================================================================
module alu64_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       control_input,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] out,
    output logic             overflow
);

    logic [WIDTH-1:0] w_arith_sum;
    logic             w_arith_ovf;
    logic             w_is_sub;

    logic [WIDTH-1:0] out_d;
    logic [WIDTH-1:0] out_q;
    logic             overflow_d;
    logic             overflow_q;

    assign w_is_sub = (control_input == ALU_SUB);

    add_sub64 #(
        .WIDTH    (WIDTH)
    ) u_add_sub64 (
        .a        (A),
        .b        (B),
        .sub      (w_is_sub),
        .sum      (w_arith_sum),
        .overflow (w_arith_ovf)
    );

    always_comb begin
        out_d      = '0;
        overflow_d = 1'b0;
        case (control_input)
            ALU_ADD, ALU_SUB: begin
                out_d      = w_arith_sum;
                overflow_d = w_arith_ovf;
            end
            ALU_AND: out_d = A & B;
            ALU_XOR: out_d = A ^ B;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            out_q      <= out_d;
            overflow_q <= overflow_d;
        end
    end

    assign out      = out_q;
    assign overflow = overflow_q;

endmodule : alu64_unit
`default_nettype wire

// File: tb/tb_alu64_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu64_unit
//  Purpose  : Self-checking bench for alu64_unit against an arithmetic model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu64_unit;

    localparam logic [63:0] C_MAX_POS = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] C_MIN_NEG = 64'h8000_0000_0000_0000;
    localparam logic [63:0] C_ALL_ONE = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk;
    logic        reset;
    logic [1:0]  control_input;
    logic [63:0] A;
    logic [63:0] B;
    logic [63:0] out;
    logic        overflow;

    int n_cmp;
    int n_err;

    alu64_unit #(
        .WIDTH         (64)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .control_input (control_input),
        .A             (A),
        .B             (B),
        .out           (out),
        .overflow      (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: exact signed arithmetic in 65 bits; overflow means the exact
    // result does not fit in a signed 64-bit word.
    function automatic void model(input logic [1:0] op, input logic [63:0] a,
                                  input logic [63:0] b, output logic [63:0] r,
                                  output logic v);
        logic signed [64:0] sa;
        logic signed [64:0] sb;
        logic signed [64:0] ex;
        sa = $signed({a[63], a});
        sb = $signed({b[63], b});
        r  = '0;
        v  = 1'b0;
        case (op)
            2'd0: begin ex = sa + sb; r = ex[63:0]; v = (ex > 65'sd9223372036854775807) || (ex < -65'sd9223372036854775808); end
            2'd1: begin ex = sa - sb; r = ex[63:0]; v = (ex > 65'sd9223372036854775807) || (ex < -65'sd9223372036854775808); end
            2'd2: r = a & b;
            default: r = a ^ b;
        endcase
    endfunction

    // One clock: drive on the falling edge, check just after the rising edge.
    task automatic step(input string tag, input logic rst, input logic [1:0] op,
                        input logic [63:0] a, input logic [63:0] b);
        logic [63:0] er;
        logic        ev;
        @(negedge clk);
        reset         = rst;
        control_input = op;
        A             = a;
        B             = b;
        @(posedge clk);
        #1;
        if (rst) begin
            er = '0;
            ev = 1'b0;
        end else begin
            model(op, a, b, er, ev);
        end
        check_val({tag, ".out"}, out, er);
        check_val({tag, ".ovf"}, {63'd0, overflow}, {63'd0, ev});
    endtask

    function automatic logic [63:0] pick_operand();
        logic [63:0] specials [6];
        specials[0] = C_MAX_POS;
        specials[1] = C_MIN_NEG;
        specials[2] = C_ALL_ONE;
        specials[3] = 64'd0;
        specials[4] = 64'd1;
        specials[5] = 64'h8000_0000_0000_0001;
        if ($urandom_range(0, 3) == 0)
            return specials[$urandom_range(0, 5)];
        return {$urandom, $urandom};
    endfunction

    initial begin
        n_cmp         = 0;
        n_err         = 0;
        reset         = 1'b1;
        control_input = 2'd0;
        A             = '0;
        B             = '0;

        step("rst0", 1'b1, 2'd0, 64'd5, 64'd3);
        step("rst1", 1'b1, 2'd0, 64'd5, 64'd3);
        step("rel",  1'b0, 2'd0, 64'd5, 64'd3);
        check_val("rel_const", out, 64'd8);

        step("add_maxp1", 1'b0, 2'd0, C_MAX_POS, 64'd1);
        check_val("add_maxp1_const", {out[63:1], overflow}, {C_MIN_NEG[63:1], 1'b1});
        step("add_m1p1",  1'b0, 2'd0, C_ALL_ONE, 64'd1);
        step("sub_10m3",  1'b0, 2'd1, 64'd10, 64'd3);
        check_val("sub_10m3_const", out, 64'd7);
        step("sub_3m10",  1'b0, 2'd1, 64'd3, 64'd10);
        check_val("sub_3m10_const", out, 64'hFFFF_FFFF_FFFF_FFF9);
        step("sub_minm1", 1'b0, 2'd1, C_MIN_NEG, 64'd1);
        check_val("sub_minm1_ovf", {63'd0, overflow}, 64'd1);
        step("sub_0mmin", 1'b0, 2'd1, 64'd0, C_MIN_NEG);
        check_val("sub_0mmin_const", out, C_MIN_NEG);
        step("and",       1'b0, 2'd2, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00);
        check_val("and_const", out, 64'hF000_F000_F000_F000);
        step("xor",       1'b0, 2'd3, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00);
        check_val("xor_const", out, 64'h0FF0_0FF0_0FF0_0FF0);
        step("and_ovf0",  1'b0, 2'd2, C_MAX_POS, C_MAX_POS);
        step("xor_ovf0",  1'b0, 2'd3, C_MIN_NEG, C_MAX_POS);

        for (int i = 0; i < 8; i++)
            step("b2b", 1'b0, i[1:0], pick_operand(), pick_operand());

        for (int i = 0; i < 6; i++)
            step("midrst", (i == 3), 2'd0, {$urandom, $urandom}, {$urandom, $urandom});

        for (int i = 0; i < 300; i++)
            step("rand", 1'b0, 2'($urandom_range(0, 3)), pick_operand(), pick_operand());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no completion expected finish before 100000");
        $fatal(1);
    end

endmodule : tb_alu64_unit
`default_nettype wire
